ring_buffer_mc: RTL

Multi-channel successor to the single-queue ring buffer: CHANNELS independent FIFO queues, each LENGTH entries of WIDTH bits, behind one shared enqueue port and one shared dequeue port, each steered by a channel index. It adds per-channel fill levels, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered dequeue-valid strobe. It sits between multi-source producers and a single arbitrated consumer.

---
 rtl/ring_buffer_mc.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ring_buffer_mc.sv
// Multi-channel ring buffer: CHANNELS independent FIFOs sharing one enqueue and one dequeue port.
// Per-channel level, threshold flags and sticky error bits; popped data is registered.
module ring_buffer_mc #(
    parameter int WIDTH        = 8,
    parameter int LENGTH       = 5,
    parameter int CHANNELS     = 4,
    parameter int OVERWRITABLE = 0,
    parameter int AFULL_LVL    = LENGTH - 1,
    parameter int AEMPTY_LVL   = 1,
    parameter int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LW           = $clog2(LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enqueue_i,
    input  logic [CW-1:0]          enq_ch_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   dequeue_i,
    input  logic [CW-1:0]          deq_ch_i,
    input  logic                   clear_err_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic [CW-1:0]          deq_ch_o,
    output logic [CHANNELS-1:0]    full,
    output logic [CHANNELS-1:0]    empty,
    output logic [CHANNELS-1:0]    almost_full,
    output logic [CHANNELS-1:0]    almost_empty,
    output logic [CHANNELS*LW-1:0] level_o,
    output logic [CHANNELS-1:0]    overflow_o,
    output logic [CHANNELS-1:0]    underflow_o
);

    localparam int PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    // Handshake: requests have no ready; a read accepted at edge N raises valid_o for exactly
    // the cycle after N, with data_o/deq_ch_o holding the popped word until the next accepted read.

    logic [WIDTH-1:0]    mem_q   [CHANNELS][LENGTH];
    logic [PW-1:0]       head_q  [CHANNELS];
    logic [PW-1:0]       head_d  [CHANNELS];
    logic [PW-1:0]       tail_q  [CHANNELS];
    logic [PW-1:0]       tail_d  [CHANNELS];
    logic [LW-1:0]       level_q [CHANNELS];
    logic [LW-1:0]       level_d [CHANNELS];

    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       deq_ch_q, deq_ch_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] udf_q, udf_d;

    logic                enq_valid, deq_valid;
    logic [CHANNELS-1:0] enq_sel, deq_sel;
    logic [CHANNELS-1:0] is_full, is_empty;
    logic [CHANNELS-1:0] deq_ok, enq_store, overwrite;
    logic [CHANNELS-1:0] ovf_set, udf_set;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (int'(p) == LENGTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign enq_valid = enqueue_i && (int'(enq_ch_i) < CHANNELS);
    assign deq_valid = dequeue_i && (int'(deq_ch_i) < CHANNELS);

    always_comb begin
        enq_sel   = '0;
        deq_sel   = '0;
        is_full   = '0;
        is_empty  = '0;
        deq_ok    = '0;
        enq_store = '0;
        overwrite = '0;
        ovf_set   = '0;
        udf_set   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            enq_sel[c]  = enq_valid && (int'(enq_ch_i) == c);
            deq_sel[c]  = deq_valid && (int'(deq_ch_i) == c);
            is_full[c]  = (int'(level_q[c]) == LENGTH);
            is_empty[c] = (level_q[c] == '0);
            deq_ok[c]   = deq_sel[c] && !is_empty[c];
            // A simultaneous pop frees the slot, so a full channel still accepts the write.
            enq_store[c] = enq_sel[c] && (!is_full[c] || (OVERWRITABLE != 0) || deq_ok[c]);
            overwrite[c] = enq_store[c] && is_full[c] && !deq_ok[c];
            ovf_set[c]   = enq_sel[c] && !enq_store[c];
            udf_set[c]   = deq_sel[c] && is_empty[c];
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            head_d[c]  = (deq_ok[c] || overwrite[c]) ? next_ptr(head_q[c]) : head_q[c];
            tail_d[c]  = enq_store[c] ? next_ptr(tail_q[c]) : tail_q[c];
            level_d[c] = level_q[c];
            if (enq_store[c] && !deq_ok[c] && !is_full[c]) begin
                level_d[c] = level_q[c] + LW'(1);
            end else if (deq_ok[c] && !enq_store[c]) begin
                level_d[c] = level_q[c] - LW'(1);
            end
        end
    end

    always_comb begin
        data_d   = data_q;
        deq_ch_d = deq_ch_q;
        valid_d  = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (deq_ok[c]) begin
                data_d   = mem_q[c][head_q[c]];
                deq_ch_d = CW'(c);
                valid_d  = 1'b1;
            end
        end
        // A new error in the clearing cycle still sets its bit.
        ovf_d = (clear_err_i ? '0 : ovf_q) | ovf_set;
        udf_d = (clear_err_i ? '0 : udf_q) | udf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                head_q[c]  <= '0;
                tail_q[c]  <= '0;
                level_q[c] <= '0;
            end
            data_q   <= '0;
            valid_q  <= 1'b0;
            deq_ch_q <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                head_q[c]  <= head_d[c];
                tail_q[c]  <= tail_d[c];
                level_q[c] <= level_d[c];
            end
            data_q   <= data_d;
            valid_q  <= valid_d;
            deq_ch_q <= deq_ch_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (enq_store[c]) begin
                    mem_q[c][tail_q[c]] <= data_i;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            full[c]              = is_full[c];
            empty[c]             = is_empty[c];
            almost_full[c]       = (int'(level_q[c]) >= AFULL_LVL);
            almost_empty[c]      = (int'(level_q[c]) <= AEMPTY_LVL);
            level_o[c*LW +: LW]  = level_q[c];
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign deq_ch_o    = deq_ch_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule
